// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   state_t         : arbiter FSM encoding (idle / owned)
//   DEF_*           : default parameter values for the arbiter
//   onehot_to_idx() : index of the set bit in a one-hot vector (up to 8 bits)
package bus_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_SEL_W    = 2;
  localparam int DEF_MAX_HOLD = 15;

  // Returns 0 for an all-zero vector; callers qualify with a non-zero check.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_last  : index of the most recent winner; scan starts at i_last+1
//   i_excl  : mask of requesters to skip this time
//   o_idx   : winning index (0 when nothing found)
//   o_found : high when at least one unmasked request is pending
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_last,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_found
);

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;
  int                 w_j;

  assign w_cand = i_req & ~i_excl;

  // Walk from the farthest slot back to last+1 so the nearest candidate
  // is the final assignment and therefore wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    w_rot   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j   = (int'(i_last) + k) % NUM_REQ;
      w_rot = w_cand >> w_j;
      if (w_rot[0]) begin
        o_idx   = SEL_W'(w_j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one datapath port between NUM_REQ requesters.
//   i_clk         : system clock
//   i_rst_n       : synchronous active-low reset
//   i_req         : per-requester level request
//   i_done        : per-requester release strobe (owner's bit only)
//   i_data_in     : packed requester data, requester i at [i*DATA_W +: DATA_W]
//   o_grant       : registered one-hot grant
//   o_sel         : registered binary owner index
//   o_bus_valid   : OR of grant bits
//   o_bus_data    : owner's data slice, 0 when no owner
//   o_timeout_err : one-cycle pulse after a hold-limit forced release
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_done,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_in,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_bus_valid,
  output logic [DATA_W-1:0]         o_bus_data,
  output logic                      o_timeout_err
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic               w_owner_req;
  logic               w_owner_done;
  logic               w_hit_max;
  logic               w_release;
  logic               w_forced;
  logic [NUM_REQ-1:0] w_excl;
  logic [SEL_W-1:0]   w_win_idx;
  logic               w_found;
  logic [DATA_W-1:0]  w_mux;

  // r_grant is the owner's one-hot mask, so it selects the owner's bits.
  assign w_owner_req  = |(i_req & r_grant);
  assign w_owner_done = |(i_done & r_grant);
  assign w_hit_max    = (r_cnt == HOLD_LAST);
  assign w_release    = (r_state == ST_OWN) && (w_owner_done || !w_owner_req || w_hit_max);
  // A done or req drop landing on the last cycle counts as a normal release.
  assign w_forced     = w_release && w_hit_max && w_owner_req && !w_owner_done;

  // Skip the outgoing owner only when someone else is waiting; a lone
  // persistent requester is simply re-granted.
  assign w_excl = ((r_state == ST_OWN) && ((i_req & ~r_grant) != '0)) ? r_grant : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .i_excl  (w_excl),
    .o_idx   (w_win_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = NUM_REQ'(1) << w_win_idx;
          w_sel_nxt   = w_win_idx;
          w_last_nxt  = w_win_idx;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_OWN: begin
        if (w_release) begin
          w_timeout_nxt = w_forced;
          w_cnt_nxt     = 8'd0;
          if (w_found) begin
            w_grant_nxt = NUM_REQ'(1) << w_win_idx;
            w_sel_nxt   = w_win_idx;
            w_last_nxt  = w_win_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_last    <= SEL_W'(NUM_REQ - 1);
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_sel == SEL_W'(i)) w_mux = i_data_in[i*DATA_W +: DATA_W];
    end
  end

  assign o_grant       = r_grant;
  assign o_sel         = r_sel;
  assign o_bus_valid   = |r_grant;
  assign o_bus_data    = o_bus_valid ? w_mux : '0;
  assign o_timeout_err = r_timeout;

endmodule
